// File: rtl/norm_share_ctrl_if.sv
// Bus bundle between the requesting arithmetic cores, the shared
// normalizer and the downstream rounder.
//
// Handshake: every channel transfers on a rising clock edge where its valid
// and ready are both high. A requester keeps req_valid and its req_data slice
// stable until it is accepted. req_ready may depend combinationally on
// req_valid and out_ready. out_valid never depends on out_ready, and the out_*
// payload is held stable while out_valid is high and out_ready is low.
interface norm_share_ctrl_if #(
    parameter int W    = 64,
    parameter int LW   = 6,
    parameter int NREQ = 3,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_mant;
    logic [LW:0]       out_lz;
    logic              out_zero;
    logic [IDW-1:0]    out_id;

    // Requester/rounder side.
    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_mant, out_lz, out_zero, out_id
    );

    // Shared normalizer side.
    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_mant, out_lz, out_zero, out_id
    );
endinterface

// File: rtl/norm_share_ctrl.sv
// Shared leading-zero-count + normalize-shift unit. A round-robin arbiter
// picks one of NREQ requesters per cycle; stage 1 holds the granted operand
// and counts its leading zeros, stage 2 holds the normalized result.
module norm_share_ctrl #(
    parameter int W    = 64,
    parameter int LW   = 6,
    parameter int NREQ = 3,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    norm_share_ctrl_if.slave  bus,
    output logic              busy
);
    logic           s1_valid;
    logic [W-1:0]   s1_data;
    logic [IDW-1:0] s1_id;
    logic           s2_valid;
    logic [IDW-1:0] rr_ptr;

    logic           adv1;
    logic           adv2;
    logic           accept;
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [W-1:0]   grant_data;
    logic [IDW-1:0] rr_next;
    logic [LW:0]    s1_lz;
    logic           lz_hit;

    // Stage 2 moves when empty or drained; stage 1 moves when stage 2 does.
    // Accept is masked by reset so req_ready reads 0 while rst_n is low.
    assign adv2   = !s2_valid || bus.out_ready;
    assign adv1   = !s1_valid || adv2;
    assign accept = rst_n && adv1 && grant_found;
    assign busy   = s1_valid || s2_valid;

    // Rotating priority: first pass covers rr_ptr..NREQ-1, second pass wraps.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && bus.req_valid[i] && (IDW'(i) >= rr_ptr)) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(i);
                grant_data  = bus.req_data[i*W +: W];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && bus.req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(i);
                grant_data  = bus.req_data[i*W +: W];
            end
        end
    end

    // One-hot ready to the granted requester only.
    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (accept && (grant_idx == IDW'(i))) begin
                bus.req_ready[i] = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner, wrapping at NREQ.
    always_comb begin
        rr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Leading-zero count of the stage-1 operand; all-zero operand yields W.
    always_comb begin
        s1_lz  = (LW+1)'(W);
        lz_hit = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!lz_hit && s1_data[i]) begin
                s1_lz  = (LW+1)'(W - 1 - i);
                lz_hit = 1'b1;
            end
        end
    end

    // Round-robin pointer advances only on an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= rr_next;
        end
    end

    // Stage 1: capture the granted operand and its requester id.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_id    <= '0;
        end else if (adv1) begin
            s1_valid <= accept;
            s1_data  <= grant_data;
            s1_id    <= grant_idx;
        end
    end

    // Stage 2: normalized mantissa, count, zero flag and id; holds under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid     <= 1'b0;
            bus.out_mant <= '0;
            bus.out_lz   <= '0;
            bus.out_zero <= 1'b0;
            bus.out_id   <= '0;
        end else if (adv2) begin
            s2_valid     <= s1_valid;
            bus.out_mant <= s1_data << s1_lz;
            bus.out_lz   <= s1_lz;
            bus.out_zero <= (s1_lz == (LW+1)'(W));
            bus.out_id   <= s1_id;
        end
    end

    assign bus.out_valid = s2_valid;
endmodule

// File: tb/tb_norm_share_ctrl.sv
// Bench for the shared normalizer: a transaction-level model decides grants
// and result timing, a scoreboard queue holds expected results, and a
// monitor compares whatever the DUT presents on the output channel.
module tb_norm_share_ctrl;
    localparam int W    = 64;
    localparam int LW   = 6;
    localparam int NREQ = 3;
    localparam int IDW  = 2;
    localparam int EW   = IDW + 1 + LW + 1 + W;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy;
    always #5 clk = ~clk;

    norm_share_ctrl_if #(.W(W), .LW(LW), .NREQ(NREQ), .IDW(IDW)) bus();

    norm_share_ctrl #(.W(W), .LW(LW), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    // Requester drive state.
    bit           vld [NREQ];
    logic [W-1:0] dat [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]         = vld[i];
            bus.req_data[i*W +: W]   = dat[i];
        end
    end

    // ---------------- scoreboard / model state ----------------
    int              checks = 0;
    int              errors = 0;
    logic [EW-1:0]   exp_q[$];
    int              flight_q[$];   // accept cycle of each entry in flight
    int              rr  = 0;
    int              cyc = 0;
    bit              held = 1'b0;
    logic [EW:0]     held_val;
    logic [EW-1:0]   cur;

    assign cur = {bus.out_id, bus.out_zero, bus.out_lz, bus.out_mant};

    task automatic check(string name, logic [127:0] got, logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference result from the operand value alone.
    function automatic logic [EW-1:0] expect_res(logic [W-1:0] d, int id);
        int           bits;
        int           lz;
        logic [W-1:0] v;
        logic [W-1:0] m;
        bits = 0;
        v    = d;
        while (v != '0) begin
            v = v >> 1;
            bits++;
        end
        lz = W - bits;
        m  = (lz == W) ? '0 : (d << lz);
        return {id[IDW-1:0], (lz == W), lz[LW:0], m};
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        v = {$urandom, $urandom};
        return v >> $urandom_range(0, W);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (held) begin
                check("hold_stable", {bus.out_valid, cur}, held_val);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL result: got %0h expected nothing (t=%0t)", cur, $time);
                end else begin
                    check("result", cur, exp_q.pop_front());
                end
                held = 1'b0;
            end else if (bus.out_valid) begin
                held     = 1'b1;
                held_val = {1'b1, cur};
            end else begin
                held = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(int i, logic [W-1:0] d);
        vld[i] = 1'b1;
        dat[i] = d;
    endtask

    // One clock: model decides grant and output timing before the edge,
    // checks handshake outputs, then releases the accepted requester.
    task automatic cycle(output int g);
        bit              mv;
        bit              xfer;
        int              occ;
        logic [NREQ-1:0] want_rdy;
        @(negedge clk);
        cyc++;
        occ  = flight_q.size();
        mv   = (occ > 0) && (flight_q[0] <= cyc - 2);
        xfer = mv && bus.out_ready;
        g    = -1;
        if (occ < 2 || xfer) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (rr + k) % NREQ;
                if (g < 0 && vld[idx]) g = idx;
            end
        end
        want_rdy = '0;
        if (g >= 0) want_rdy[g] = 1'b1;
        check("out_valid", bus.out_valid, mv);
        check("req_ready", bus.req_ready, want_rdy);
        check("busy", busy, occ > 0);
        if (xfer) void'(flight_q.pop_front());
        if (g >= 0) begin
            flight_q.push_back(cyc);
            exp_q.push_back(expect_res(dat[g], g));
            rr = (g + 1) % NREQ;
        end
        @(posedge clk);
        #1;
        if (g >= 0) vld[g] = 1'b0;
    endtask

    task automatic idle(int n);
        int g;
        repeat (n) cycle(g);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_req_ready"}, bus.req_ready, 0);
        check({tag, "_out_mant"},  bus.out_mant, 0);
        check({tag, "_out_lz"},    bus.out_lz, 0);
        check({tag, "_out_zero"},  bus.out_zero, 0);
        check({tag, "_out_id"},    bus.out_id, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int g;
        int start;
        for (int i = 0; i < NREQ; i++) begin
            vld[i] = 1'b1;
            dat[i] = rnd_op();
        end
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        for (int i = 0; i < NREQ; i++) vld[i] = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Single request, then zero operand.
        set_req(0, 64'h0000_0000_0000_00F0);
        idle(4);
        set_req(1, 64'h0);
        idle(4);

        // Fairness: every requester always valid.
        start = rr;
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < NREQ; i++) if (!vld[i]) set_req(i, rnd_op());
            cycle(g);
            check("rr_order", g, (start + n) % NREQ);
        end
        for (int i = 0; i < NREQ; i++) vld[i] = 1'b0;
        idle(4);

        // Backpressure on a req2 stream, then release.
        bus.out_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            if (!vld[2]) set_req(2, rnd_op());
            cycle(g);
        end
        bus.out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            if (!vld[2]) set_req(2, rnd_op());
            cycle(g);
        end
        vld[2] = 1'b0;
        idle(4);

        // MSB already set.
        set_req(0, 64'h8000_0000_0000_0001);
        idle(4);

        // Random traffic with random downstream stalls.
        repeat (300) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!vld[i] && $urandom_range(0, 1) == 1) set_req(i, rnd_op());
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cycle(g);
        end

        // Let the random phase settle, then fill both stages and reset.
        for (int i = 0; i < NREQ; i++) vld[i] = 1'b0;
        bus.out_ready = 1'b1;
        idle(4);
        bus.out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < NREQ; i++) if (!vld[i]) set_req(i, rnd_op());
            cycle(g);
        end
        check("pre_reset_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        flight_q.delete();
        held = 1'b0;
        rr   = 0;
        for (int i = 0; i < NREQ; i++) set_req(i, rnd_op());
        @(posedge clk);
        #3 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        cycle(g);
        check("post_reset_grant", g, 0);
        for (int i = 0; i < NREQ; i++) vld[i] = 1'b0;

        // Drain with a bounded budget.
        for (int n = 0; n < 20; n++) begin
            if (exp_q.size() == 0 && flight_q.size() == 0) break;
            cycle(g);
        end
        check("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/norm_share_ctrl.md
Name: norm_share_ctrl

Overview:
- Round-robin scheduler that shares one leading-zero-count + normalize-shift datapath between NREQ requesters.
- Typical requesters: add/sub result path, multiplier product path, int-to-float converter.
- Two-stage elastic pipeline. Stage 1 registers the granted operand and counts its leading zeros. Stage 2 registers the left-shift-normalized mantissa, the count and the requester id.
- Sits between the FPU arithmetic cores and the rounder.

Parameters:
- W, 64, operand/mantissa width; power of two, at least 4.
- LW, 6, log2(W); count output is LW+1 bits.
- NREQ, 3, number of requesters, 2..4.
- IDW, 2, requester id width; NREQ <= 2**IDW.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_data  input  NREQ*W  operands; requester i occupies bits [i*W +: W].
- req_ready  output  NREQ  per-requester accept, one-hot or zero.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accept.
- out_mant  output  W  normalized mantissa; MSB = 1 unless operand zero.
- out_lz  output  LW+1  leading-zero count of the operand, 0..W.
- out_zero  output  1  operand was all zeros.
- out_id  output  IDW  requester index that produced this result.
- busy  output  1  either pipeline stage holds a valid entry.

Behaviour:
- Reset (async assert, sync deassert by the surrounding logic):
  - s1_valid=0, s2_valid=0, rr_ptr=0.
  - Outputs: out_valid=0, out_mant=0, out_lz=0, out_zero=0, out_id=0, req_ready=0, busy=0.
  - In-flight entries are discarded; no result is emitted for them.
- Handshake: a transfer occurs when valid&ready are both high at a rising edge. Requesters hold req_valid and data stable until accepted. req_ready may depend combinationally on req_valid and out_ready.
- Advance conditions:
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - accept = adv1 & (|req_valid).
- Arbitration:
  - Search req_valid from index rr_ptr upward, wrapping modulo NREQ; the first set bit is granted.
  - req_ready[g] = accept for the granted index g only.
  - On accept, rr_ptr <= (g+1) mod NREQ. rr_ptr is unchanged when there is no accept.
- Stage 1:
  - On adv1, s1 captures {operand, id=g} with s1_valid=accept.
  - Leading-zero count is computed combinationally from the s1 operand.
  - Zero operand gives count = W (e.g. 7'b1000000 for W=64).
- Stage 2:
  - On adv2, s2 captures:
    - out_lz = count.
    - out_mant = operand << count, with zero fill; gives 0 when operand is zero.
    - out_zero = (count == W).
    - out_id = s1 id.
    - s2_valid = s1_valid.
- Latency and throughput:
  - Accept at edge k means out_valid at edge k+2 with no stall.
  - Throughput is one result per cycle.
- Backpressure: while out_valid & !out_ready, the outputs hold stable. s1 fills if empty, then req_ready stays 0 for all requesters until a slot frees. No entry is lost or duplicated.
- Simultaneous events: the same-cycle out transfer and new accept are both allowed (full-rate streaming). A requester dropping req_valid before acceptance is simply not granted.
- busy = s1_valid | s2_valid.

Test Plan:
- Reset then single request: req0 data=64'h0000_0000_0000_00F0 at cycle 1, out_ready=1 → out_valid at cycle 3, out_lz=56, out_mant=64'hF000_0000_0000_0000, out_zero=0, out_id=0.
- Zero operand: req1 data=0 → out_lz=64, out_mant=0, out_zero=1, out_id=1.
- Round-robin fairness: all three requesters valid continuously for 6 cycles, out_ready=1 → grant order 0,1,2,0,1,2; six results, one per cycle, ids in that order.
- Backpressure: stream from req2 with out_ready=0 for 4 cycles → out_* stable, exactly two entries held, req_ready=0 after s1 fills; out_ready=1 → both drain in order, then accepts resume.
- MSB-set operand: data=64'h8000_0000_0000_0001 → out_lz=0, out_mant unchanged.
- Reset mid-operation: assert rst_n=0 with both stages valid → out_valid, busy, req_ready drop to 0 immediately (async), and after release next grant starts from requester 0.
